// File: rtl/inv_cipher_iter.sv
// inv_cipher_iter -- iterative AES-128 inverse cipher, one round per clock.
//
// Derives the last round key with a 10-cycle forward expansion (KEXP), then
// runs AddRoundKey with rk10 (ARK) and walks the key schedule backwards while
// applying ten inverse rounds (ROUND). The plaintext is held in DONE until the
// consumer takes it.
//
// Optional feature: define INV_CIPHER_KEY_CACHE_EN to keep the last expanded
// key (and its rk10) so a repeated key skips KEXP (latency 11 instead of 21).
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE, out_valid only in DONE, so they never overlap;
// o is stable whenever out_valid is high.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   ciphertext and key present
//   in_ready   core can accept (IDLE)
//   data       ciphertext, x[c][r] = byte 4c+r
//   key        cipher key (round-0 key), same layout
//   out_valid  plaintext valid on o
//   out_ready  consumer accepts o
//   o          plaintext, registered
//   fsm_state  current FSM state (debug)
module inv_cipher_iter (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:3][0:3][7:0]  data,
  input  logic [0:3][0:3][7:0]  key,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:3][0:3][7:0]  o,
  output logic [2:0]            fsm_state
);

  typedef logic [0:3][7:0]       word_t;
  typedef logic [0:3][0:3][7:0]  block_t;
  typedef enum logic [2:0] {IDLE, KEXP, ARK, ROUND, DONE} state_t;

  state_t     state_q, state_d;
  block_t     st_q, rk_q;
  block_t     rk_fwd, rk_bwd, sr, round_out;
  block_t     cache_rk;
  logic [3:0] r_q;
  logic       hit;

  // GF(2^8) arithmetic modulo 0x11b
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, acc;
    p   = a;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xt(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] s, acc;
    s   = a;
    acc = 8'h01;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) acc = gmul(acc, s);
      s = gmul(s, s);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // SubWord(RotWord(w)) ^ {rc,0,0,0}
  function automatic word_t t_word(input word_t w, input logic [7:0] rc);
    return {sbox(w[1]) ^ rc, sbox(w[2]), sbox(w[3]), sbox(w[0])};
  endfunction

  // Key schedule: r_q counts 1..10 in KEXP and 10..1 in ROUND, so the same
  // rcon(r_q) serves both the forward and the backward step.
  always_comb begin
    rk_fwd    = '0;
    rk_fwd[0] = rk_q[0] ^ t_word(rk_q[3], rcon(r_q));
    for (int c = 1; c < 4; c++) rk_fwd[c] = rk_q[c] ^ rk_fwd[c-1];

    rk_bwd = '0;
    for (int c = 3; c > 0; c--) rk_bwd[c] = rk_q[c] ^ rk_q[c-1];
    rk_bwd[0] = rk_q[0] ^ t_word(rk_bwd[3], rcon(r_q));
  end

  // One inverse round; row rr rotates right by rr columns.
  always_comb begin
    sr        = '0;
    round_out = '0;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        sr[c][rr] = inv_sbox(st_q[2'((c - rr) & 3)][rr]) ^ rk_bwd[c][rr];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        round_out[c][rr] = (r_q == 4'd1) ? sr[c][rr] :
          gmul(sr[c][rr], 8'h0e) ^ gmul(sr[c][2'(rr + 1)], 8'h0b) ^
          gmul(sr[c][2'(rr + 2)], 8'h0d) ^ gmul(sr[c][2'(rr + 3)], 8'h09);
  end

  // FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = hit ? ARK : KEXP;
      end
      KEXP:    if (r_q == 4'd10) state_d = ARK;
      ARK:     state_d = ROUND;
      ROUND:   if (r_q == 4'd1) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fsm_state = state_q;

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= '0;
      rk_q <= '0;
      r_q  <= '0;
      o    <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          st_q <= data;
          rk_q <= hit ? cache_rk : key;
          r_q  <= 4'd1;
        end
        KEXP: begin
          rk_q <= rk_fwd;
          r_q  <= r_q + 4'd1;
        end
        ARK: begin
          st_q <= st_q ^ rk_q;
          r_q  <= 4'd10;
        end
        ROUND: begin
          st_q <= round_out;
          rk_q <= rk_bwd;
          r_q  <= r_q - 4'd1;
          if (r_q == 4'd1) o <= round_out;
        end
        default: ;
      endcase
    end
  end

`ifdef INV_CIPHER_KEY_CACHE_EN
  block_t cache_key;
  logic   cache_valid;

  assign hit = cache_valid && (key == cache_key);

  // A miss invalidates the entry at accept; it becomes valid only once the
  // expansion for that key completes, so a reset during KEXP leaves it clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_key   <= '0;
      cache_rk    <= '0;
      cache_valid <= 1'b0;
    end else if (state_q == IDLE && in_valid && !hit) begin
      cache_key   <= key;
      cache_valid <= 1'b0;
    end else if (state_q == KEXP && r_q == 4'd10) begin
      cache_rk    <= rk_fwd;
      cache_valid <= 1'b1;
    end
  end
`else
  assign hit      = 1'b0;
  assign cache_rk = '0;
`endif

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Testbench for inv_cipher_iter: FIPS-197 vectors, back-pressure, busy-input
// noise, reset mid-round, cache latency and random blocks against a
// straightforward byte-array AES decryption model.
module tb_inv_cipher_iter;

`ifdef INV_CIPHER_KEY_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] D_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] D_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] data_i, key_i, o;
  logic [2:0]   fsm_state;

  inv_cipher_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data(data_i), .key(key_i), .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .fsm_state(fsm_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] exp_q[$];

  // cache model: last key that completed an expansion
  bit           c_valid = 1'b0;
  logic [127:0] c_key = '0;

  // reference model tables
  logic [7:0] sb[256];
  logic [7:0] isb[256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = a, acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Walk the multiplicative group with generator 3 and its inverse in lockstep.
  task automatic build_tables();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^
              {q[3:0], q[7:4]} ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] ref_dec(input logic [127:0] ct, input logic [127:0] k);
    logic [7:0] w[176];
    logic [7:0] s[16];
    logic [7:0] t[16];
    logic [7:0] tmp[4];
    logic [7:0] rc;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        tmp = '{sb[w[4*i-3]] ^ rc, sb[w[4*i-2]], sb[w[4*i-1]], sb[w[4*i-4]]};
        rc = gm(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ w[160+i];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*((c+r)%4)+r] = s[4*c+r];
      for (int i = 0; i < 16; i++) t[i] = isb[t[i]] ^ w[16*rnd+i];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gm(t[4*c+r], 8'h0e) ^ gm(t[4*c+(r+1)%4], 8'h0b) ^
                       gm(t[4*c+(r+2)%4], 8'h0d) ^ gm(t[4*c+(r+3)%4], 8'h09);
      end else begin
        s = t;
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_block(input logic [127:0] d, input logic [127:0] k,
                           input logic [127:0] exp, input bit noise,
                           input int hold, input string tag);
    int lat, w, lat_exp;
    logic [127:0] e;
    lat_exp = (CACHE_ON && c_valid && k == c_key) ? 11 : 21;
    exp_q.push_back(exp);
    data_i = d;
    key_i = k;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    tick();                                   // accept edge
    in_valid = 1'b0;
    data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 128'(lat), 128'(lat_exp));
    e = exp_q.pop_front();
    check({tag, "_o"}, o, e);
    check({tag, "_in_ready_low"}, 128'(in_ready), 128'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      check({tag, "_hold_o"}, o, e);
      check({tag, "_hold_valid"}, 128'(out_valid), 128'd1);
      check({tag, "_hold_in_ready"}, 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_after_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_after_in_ready"}, 128'(in_ready), 128'd1);
    c_valid = 1'b1;
    c_key = k;
  endtask

  initial begin
    logic [127:0] k, d;
    build_tables();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    data_i = '0;
    key_i = '0;
    #1 rst = 1'b0;
    #2;
    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_o", o, 128'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("post_reset_in_ready", 128'(in_ready), 128'd1);

    // FIPS-197 vectors
    run_block(D_C1, K_C1, P_C1, 1'b0, 0, "c1");
    run_block(D_B,  K_B,  P_B,  1'b0, 0, "b");
    // cache: same key back-to-back
    run_block(D_C1, K_C1, P_C1, 1'b0, 0, "c1_miss");
    run_block(D_C1, K_C1, P_C1, 1'b0, 0, "c1_hit");
    run_block(D_B,  K_B,  P_B,  1'b0, 0, "b_after");
    // back-pressure and busy-input noise
    run_block(D_C1, K_C1, P_C1, 1'b0, 5, "backpressure");
    run_block(D_C1, K_C1, P_C1, 1'b1, 0, "busy_noise");

    // reset in ROUND with r=5, using a fresh key so the path is 21 cycles
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    data_i = D_C1;
    key_i = k;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    rst = 1'b0;
    #1;
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_o", o, 128'd0);
    check("abort_in_ready", 128'(in_ready), 128'd1);
    c_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("abort_release_in_ready", 128'(in_ready), 128'd1);
    run_block(D_C1, K_C1, P_C1, 1'b0, 0, "after_abort");

    // random blocks; odd iterations reuse the previous key
    k = '0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) k = {$urandom(), $urandom(), $urandom(), $urandom()};
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_block(d, k, ref_dec(d, k), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
